// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: gap/show timing, LFSR hole choice, whack
// detection, score/miss bookkeeping and a show window that shrinks per hit.
module mole_game_ctrl #(
  parameter int unsigned MOLE_ON_CYCLES = 25000000,
  parameter int unsigned MIN_ON_CYCLES  = 6250000,
  parameter int unsigned STEP_CYCLES    = 1250000,
  parameter int unsigned GAP_CYCLES     = 12500000,
  parameter int unsigned GAME_MOLES     = 20,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] btn,
  output logic [2:0] oval_select,
  output logic       mole_visible,
  output logic       hit_pulse,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_t;

  state_t      state;
  logic [31:0] timer;
  logic [31:0] on_time;
  logic [31:0] mole_cnt;
  logic [7:0]  lfsr;
  logic [2:0]  prev;
  logic [4:0]  btn_q;
  logic        start_q;

  logic        start_edge;
  logic [4:0]  btn_edge;
  logic        hit_edge;
  logic        last_mole;
  logic        show_timeout;
  logic [2:0]  next_hole;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Shrink the window by one step but never below the floor; on_time never
  // drops under MIN_ON_CYCLES, so the subtraction below cannot wrap.
  function automatic logic [31:0] next_on_time(input logic [31:0] cur);
    if (cur - MIN_ON_CYCLES >= STEP_CYCLES)
      return cur - STEP_CYCLES;
    else
      return MIN_ON_CYCLES;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Map the LFSR onto holes 1..5 and bump to the next hole on a repeat.
  function automatic logic [2:0] pick_hole(input logic [7:0] l, input logic [2:0] p);
    logic [7:0] r;
    logic [2:0] c;
    r = l % 8'd5;
    c = r[2:0] + 3'd1;
    if (c == p)
      c = (c == 3'd5) ? 3'd1 : c + 3'd1;
    return c;
  endfunction

  function automatic logic [4:0] hole_mask(input logic [2:0] h);
    return 5'b00001 << (h - 3'd1);
  endfunction

  assign start_edge   = start & ~start_q;
  assign btn_edge     = btn & ~btn_q;
  assign hit_edge     = |(btn_edge & hole_mask(oval_select));
  assign last_mole    = (mole_cnt + 32'd1 == GAME_MOLES);
  assign show_timeout = (timer == on_time - 32'd1);
  assign next_hole    = pick_hole(lfsr, prev);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      oval_select  <= 3'd1;
      mole_visible <= 1'b0;
      hit_pulse    <= 1'b0;
      score        <= 8'd0;
      misses       <= 8'd0;
      game_over    <= 1'b0;
      timer        <= 32'd0;
      mole_cnt     <= 32'd0;
      on_time      <= MOLE_ON_CYCLES;
      lfsr         <= LFSR_SEED;
      prev         <= 3'd1;
      btn_q        <= 5'd0;
      start_q      <= 1'b0;
    end else begin
      lfsr      <= lfsr_next(lfsr);
      btn_q     <= btn;
      start_q   <= start;
      hit_pulse <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state        <= GAP;
            timer        <= 32'd0;
            score        <= 8'd0;
            misses       <= 8'd0;
            mole_cnt     <= 32'd0;
            on_time      <= MOLE_ON_CYCLES;
            game_over    <= 1'b0;
            mole_visible <= 1'b0;
          end
        end
        GAP: begin
          if (timer == GAP_CYCLES - 32'd1) begin
            state        <= SHOW;
            oval_select  <= next_hole;
            prev         <= next_hole;
            mole_visible <= 1'b1;
            timer        <= 32'd0;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        SHOW: begin
          // A correct whack wins over a timeout landing on the same cycle.
          if (hit_edge || show_timeout) begin
            if (hit_edge) begin
              score     <= sat_inc8(score);
              hit_pulse <= 1'b1;
              on_time   <= next_on_time(on_time);
            end else begin
              misses <= sat_inc8(misses);
            end
            mole_cnt     <= mole_cnt + 32'd1;
            mole_visible <= 1'b0;
            timer        <= 32'd0;
            if (last_mole) begin
              state     <= DONE;
              game_over <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: directed per-mole table, reset/hit corner cases,
// and a randomized run compared cycle by cycle against a rule-level model.
module tb_mole_game_ctrl;

  localparam int unsigned ON_C   = 20;
  localparam int unsigned MIN_C  = 8;
  localparam int unsigned STEP_C = 5;
  localparam int unsigned GAP_C  = 4;
  localparam int unsigned MOLES  = 4;
  localparam logic [7:0]  SEED   = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] btn;
  logic [2:0] oval_select;
  logic       mole_visible;
  logic       hit_pulse;
  logic [7:0] score;
  logic [7:0] misses;
  logic       game_over;

  int errors = 0;
  int checks = 0;

  mole_game_ctrl #(
    .MOLE_ON_CYCLES(ON_C),
    .MIN_ON_CYCLES (MIN_C),
    .STEP_CYCLES   (STEP_C),
    .GAP_CYCLES    (GAP_C),
    .GAME_MOLES    (MOLES),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .btn         (btn),
    .oval_select (oval_select),
    .mole_visible(mole_visible),
    .hit_pulse   (hit_pulse),
    .score       (score),
    .misses      (misses),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  // Rule-level reference: phase plus a countdown of cycles left in it.
  localparam int PH_IDLE = 0, PH_GAP = 1, PH_SHOW = 2, PH_DONE = 3;
  int         m_phase, m_left, m_on, m_cnt, m_score, m_miss, m_oval, m_prev, m_cand;
  bit         m_hit, m_se;
  logic [4:0] m_be, m_bp;
  logic       m_sp;
  logic [7:0] m_lfsr;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = PH_IDLE; m_left = 0; m_on = ON_C; m_cnt = 0;
      m_score = 0; m_miss = 0; m_oval = 1; m_prev = 1; m_hit = 0;
      m_lfsr = SEED; m_bp = 5'd0; m_sp = 1'b0;
    end else begin
      m_se  = start && !m_sp;
      m_be  = btn & ~m_bp;
      m_hit = 0;
      if ((m_phase == PH_IDLE || m_phase == PH_DONE) && m_se) begin
        m_phase = PH_GAP; m_left = GAP_C; m_score = 0; m_miss = 0;
        m_cnt = 0; m_on = ON_C;
      end else if (m_phase == PH_GAP) begin
        m_left--;
        if (m_left == 0) begin
          m_cand = int'(m_lfsr) % 5 + 1;
          if (m_cand == m_prev) m_cand = m_cand % 5 + 1;
          m_oval = m_cand; m_prev = m_cand;
          m_phase = PH_SHOW; m_left = m_on;
        end
      end else if (m_phase == PH_SHOW) begin
        m_left--;
        if (m_be[m_oval-1] || m_left == 0) begin
          if (m_be[m_oval-1]) begin
            m_hit = 1;
            m_score = (m_score >= 255) ? 255 : m_score + 1;
            m_on = (m_on - int'(STEP_C) < int'(MIN_C)) ? MIN_C : m_on - STEP_C;
          end else begin
            m_miss = (m_miss >= 255) ? 255 : m_miss + 1;
          end
          m_cnt++;
          m_phase = (m_cnt == MOLES) ? PH_DONE : PH_GAP;
          m_left = GAP_C;
        end
      end
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      m_sp = start; m_bp = btn;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string name);
    logic [21:0] act, exp;
    act = {oval_select, mole_visible, hit_pulse, score, misses, game_over};
    exp = {3'(m_oval), m_phase == PH_SHOW, m_hit, 8'(m_score), 8'(m_miss), m_phase == PH_DONE};
    chk(name, 32'(act), 32'(exp));
  endtask

  typedef struct {
    bit start_before;
    int press_at;
    int wrong_at;
    int exp_len;
    int exp_score;
    int exp_miss;
    bit exp_over;
  } mole_t;

  mole_t tbl[8];

  task automatic run_mole(input mole_t r);
    int len;
    int waited;
    if (r.start_before) begin
      start = 1'b1;
      step(1);
      chk("restart_clear", {score, misses, game_over}, 0);
      start = 1'b0;
    end
    waited = 0;
    while (mole_visible !== 1'b1 && waited < 50) begin
      step(1);
      waited++;
    end
    chk("mole_up", mole_visible, 1);
    len = 1;
    for (int guard = 0; guard < 100; guard++) begin
      btn = 5'd0;
      if (len == r.press_at)
        btn = 5'(5'b1 << (m_oval - 1));
      else if (r.wrong_at != 0 && len >= r.wrong_at && len < r.wrong_at + 6 &&
               ((len - r.wrong_at) % 2) == 0)
        btn = 5'(5'b1 << (m_oval % 5));
      step(1);
      if (mole_visible !== 1'b1) break;
      len++;
    end
    btn = 5'd0;
    chk("show_len", len, r.exp_len);
    chk("end_hit", hit_pulse, (r.press_at != 0) ? 1 : 0);
    chk("end_score", score, r.exp_score);
    chk("end_miss", misses, r.exp_miss);
    chk("end_over", game_over, r.exp_over);
  endtask

  initial begin
    int  moles, last_hole, cyc, waited;
    bit  prev_vis;
    bit  [5:1] seen;

    tbl[0] = '{0, 0,  0, 15, 1, 1, 0};
    tbl[1] = '{0, 15, 2, 15, 2, 1, 0};
    tbl[2] = '{0, 0,  0, 10, 2, 2, 1};
    tbl[3] = '{1, 1,  0, 1,  1, 0, 0};
    tbl[4] = '{0, 1,  0, 1,  2, 0, 0};
    tbl[5] = '{0, 1,  0, 1,  3, 0, 0};
    tbl[6] = '{0, 0,  0, 8,  3, 1, 1};
    tbl[7] = '{1, 0,  0, 20, 0, 1, 0};

    reset = 1'b1; start = 1'b0; btn = 5'd0;
    #2;
    step(3);
    chk("reset_lfsr", dut.lfsr, SEED);
    chk("reset_outs", {oval_select, mole_visible, hit_pulse, score, misses, game_over}, {3'd1, 19'd0});
    reset = 1'b0;
    step(1);
    chk("idle_outs", {oval_select, mole_visible, score, game_over}, {3'd1, 10'd0});

    start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      chk("start_latency", mole_visible, (i == 5) ? 1 : 0);
    end
    start = 1'b0;

    step(2);
    btn = 5'(5'b1 << (m_oval - 1));
    step(1);
    chk("hit_pulse", hit_pulse, 1);
    chk("hit_score", score, 1);
    chk("hit_vis", mole_visible, 0);
    btn = 5'd0;
    step(1);
    chk("hit_pulse_clear", hit_pulse, 0);

    foreach (tbl[i]) run_mole(tbl[i]);

    waited = 0;
    while (mole_visible !== 1'b1 && waited < 50) begin
      step(1);
      waited++;
    end
    step(3);
    reset = 1'b1;
    step(1);
    chk("midshow_reset_outs", {oval_select, mole_visible, hit_pulse, score, misses, game_over}, {3'd1, 19'd0});
    chk("midshow_reset_lfsr", dut.lfsr, SEED);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle_after_reset", {mole_visible, game_over}, 0);
    end

    moles = 0; last_hole = 1; seen = '0; prev_vis = 0; cyc = 0;
    while (moles < 200 && cyc < 20000) begin
      reset = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 3) == 0);
      btn   = 5'($urandom);
      step(1);
      cyc++;
      cmp_model("random_cycle");
      if (reset) begin
        last_hole = 1;
      end else if (mole_visible && !prev_vis) begin
        moles++;
        chk("hole_range", (oval_select >= 3'd1 && oval_select <= 3'd5), 1);
        chk("hole_repeat", (int'(oval_select) != last_hole), 1);
        if (oval_select >= 3'd1 && oval_select <= 3'd5) seen[oval_select] = 1'b1;
        last_hole = oval_select;
      end
      prev_vis = mole_visible;
    end
    chk("random_moles_reached", (moles >= 200), 1);
    chk("all_holes_seen", seen, 5'b11111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
- Game controller that sits directly upstream of the mole renderer and drives its 3-bit hole select (1..5).
- Sequences mole appearances: gap, then a pseudo-random hole shown for a limited window.
- Detects whacks from five debounced, level-type hole buttons.
- Keeps score and miss counts, shortens the show window as the player scores, and ends the game after a fixed number of moles.

Parameters:
- MOLE_ON_CYCLES, 25000000: initial show-window length in clk cycles.
- MIN_ON_CYCLES, 6250000: floor for the show window.
- STEP_CYCLES, 1250000: show-window reduction per hit.
- GAP_CYCLES, 12500000: no-mole interval before each mole.
- GAME_MOLES, 20: moles per game.
- LFSR_SEED, 8'hA5: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; a rising edge starts a game
- btn  in  5  debounced hole buttons, level; btn[i] corresponds to hole i+1
- oval_select  out  3  current hole, 1..5, feeds the renderer
- mole_visible  out  1  high while a mole is up; downstream gates drawing with this
- hit_pulse  out  1  one-cycle pulse on a correct whack
- score  out  8  hits this game, saturating at 255
- misses  out  8  timed-out moles this game, saturating at 255
- game_over  out  1  high in DONE

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: state=IDLE, oval_select=3'd1, mole_visible=0, hit_pulse=0, score=0, misses=0, game_over=0, timer=0, mole_cnt=0, on_time=MOLE_ON_CYCLES, lfsr=LFSR_SEED, prev=3'd1, btn_q=0, start_q=0.
- Reset asserted mid-game restores all of the above on the next edge; no partial state survives.
- Edge detection:
  - btn_q and start_q are registered copies of btn and start.
  - edge = in & ~q; it is used in the same cycle it is computed.
  - The resulting state change is visible one cycle after the input rises.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1; shifts left every cycle in every state, feedback enters bit 0.
  - cand = (lfsr mod 5)+1.
  - If cand==prev, use hole (cand mod 5)+1 instead, so hole 5 wraps to 1.
  - The chosen hole is latched into oval_select and prev.
- States:
  - IDLE: start edge → GAP; score, misses, mole_cnt and on_time are cleared or reloaded; timer=0.
  - GAP:
    - mole_visible=0.
    - timer increments each cycle.
    - At timer==GAP_CYCLES-1 → SHOW; hole is picked; mole_visible=1 from the first SHOW cycle; timer=0.
  - SHOW:
    - Correct hit: edge on btn[oval_select-1] → GAP with mole_visible=0. Also score+1 (saturating), hit_pulse=1 for one cycle, mole_cnt+1, and on_time=max(on_time-STEP_CYCLES, MIN_ON_CYCLES), computed without unsigned underflow.
    - Wrong-button edges are ignored.
    - Timeout: at timer==on_time-1 with no correct edge → misses+1 (saturating), mole_cnt+1 → GAP.
    - A correct edge on the timeout cycle counts as a hit, not a miss.
    - Resolving the GAME_MOLES-th mole goes to DONE instead of GAP.
  - DONE:
    - game_over=1, mole_visible=0; score and misses hold.
    - start edge → clears/reloads as in IDLE, game_over=0 → GAP.
- start edges in GAP or SHOW are ignored.
- oval_select holds its last value outside SHOW and is never 0 or >5.
- timer is 32-bit; parameters must be ≥1 and MIN_ON_CYCLES ≤ MOLE_ON_CYCLES.

Test Plan:
Bench parameters: MOLE_ON_CYCLES=20, MIN_ON_CYCLES=8, STEP_CYCLES=5, GAP_CYCLES=4, GAME_MOLES=4.
1. Reset and start:
   - Assert reset 3 cycles, release → oval_select=1, mole_visible=0, score=0, game_over=0, lfsr=8'hA5.
   - Start edge → mole_visible rises exactly 5 cycles after the start edge (1 to enter GAP + 4 GAP).
2. Hit timing:
   - In SHOW, raise the correct btn on SHOW cycle 3 → next cycle hit_pulse=1 for one cycle, score=1, mole_visible=0.
   - The next SHOW lasts 15 cycles.
3. Timeout and wrong buttons:
   - No press → mole_visible high exactly 20 cycles, misses=1.
   - Wrong-button edges during SHOW leave score and misses unchanged.
4. Clamp and game end:
   - Hit 3 moles in a row → on_time goes 20→15→10→8 (clamped).
   - 4th mole times out → DONE, game_over=1, score=3, misses=1.
   - start edge in DONE → score=0, misses=0, game_over=0.
5. Hole selection:
   - Over 200 consecutive moles, oval_select is always in 1..5 and never equals the previous hole.
   - Every hole appears at least once.
6. Simultaneous events and reset:
   - Correct btn edge on the final SHOW cycle → counted as a hit.
   - Assert reset mid-SHOW → next cycle all outputs at reset values, state IDLE.
